muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle sequencer that implements MULT/MULTU/DIV/DIVU by iterating the shared 32-bit ALU, using its add (4'b0010) and subtract (4'b0110) operations, for 32 cycles. It sits beside the single-cycle datapath and owns the ALU only while busy. Results go to the HI/LO registers it holds. The stall logic holds the pipeline on busy and takes hi/lo on the done pulse.

Parameters:
WIDTH, 32, operand width; fixed to the ALU width, so CNT_W = 6.
DIV0_LO, 32'hFFFFFFFF, quotient returned on divide-by-zero.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_val  in  32  multiplicand / dividend
rt_val  in  32  multiplier / divisor
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse; hi/lo valid from this cycle
hi  out  32  product[63:32] / remainder
lo  out  32  product[31:0] / quotient
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_ctrl  out  4  ALU control
alu_result  in  32  ALU result, combinational return

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-low (`rst_n`).
- Reset (rst_n=0 at an edge, including mid-operation): state=IDLE, busy=0, done=0, hi=lo=0, internal regs=0. The in-flight operation is discarded.
- Default ALU drive: in IDLE/FIX, alu_a=0, alu_b=0, alu_ctrl=4'b0010.
- States: IDLE, ITER, FIX.
- Start (edge E0, IDLE && start):
  - Latch op.
  - Latch magnitudes: |rs|, |rt| for signed ops (two's-complement negate done locally); raw values for unsigned ops.
  - Latch neg_q = rs[31]^rt[31] and neg_r = rs[31], signed ops only.
  - cnt=0, busy=1.
- Divide by zero (DIV/DIVU with rt_val=0): go to FIX directly. At E1: hi=rs_val unmodified, lo=DIV0_LO, done=1.
- start while busy is ignored. done never coincides with busy=1.
- Multiply, ITER state:
  - Registers P_hi (init 0), P_lo = multiplier, M = multiplicand.
  - Drive alu_a=P_hi, alu_b = P_lo[0] ? M : 0, alu_ctrl=0010.
  - Carry c = (a31&b31) | ((a31|b31)&~r31).
  - At edge: {P_hi,P_lo} <= {c, alu_result, P_lo[31:1]}.
- Divide, ITER state (restoring):
  - Registers R (init 0), Q = dividend, D = divisor.
  - Drive alu_a = {R[30:0],Q[31]}, alu_b = D, alu_ctrl=0110.
  - no_borrow = (a31&~b31) | ((a31|~b31)&~r31).
  - If R[31] | no_borrow: R <= alu_result, Q <= {Q[30:0],1}.
  - Else: R <= alu_a, Q <= {Q[30:0],0}.
- cnt increments each ITER edge. The edge with cnt==31 moves to FIX.
- FIX (one edge):
  - MULT: negate the 64-bit product if neg_q.
  - DIV: lo = neg_q ? -Q : Q; hi = neg_r ? -R : R.
  - Write hi/lo, done=1, busy=0, return to IDLE.
  - For a non-zero divisor, done is high in the cycle after edge E33, i.e. 33 edges after the start edge.
- Wrap rules:
  - 0x80000000 magnitude stays 0x80000000 as an unsigned value.
  - DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.
- hi/lo hold their values until the next FIX or reset. done deasserts the following cycle.
- ALU zero/overflow outputs are not used.

Decomposition:
- Package mips_alu_pkg:
  - ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_SLT=4'b0111.
  - Op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV.
  - State encoding.
- One sub-module: muldiv_sign_fix. It is combinational: conditional two's-complement negate of 32- and 64-bit values, used at start and in FIX.
- Carry/borrow recovery stays inline.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the start edge; busy high for 33 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; alu_ctrl=0010 throughout ITER.
- DIVU 100/7 -> lo=14, hi=2; DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5 rt=0 -> done one edge after start, hi=5, lo=0xFFFFFFFF.
- start pulsed at ITER cnt=5 with different operands -> ignored; the original result is returned on schedule.
- rst_n=0 at cnt=10 -> next cycle busy=0, done=0, hi=lo=0; a subsequent MULTU 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared ALU control codes, mul/div opcodes and sequencer state encoding.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result signs.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer iterating the shared ALU for 32 cycles.
module muldiv_seq
  import mips_alu_pkg::*;
#(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // P_hi / remainder R
  logic [WIDTH-1:0]   shq_q, shq_d;     // P_lo / quotient Q
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand M / divisor D
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic               div0_q, div0_d, done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_signed, in_div, op_div;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   mult_b, div_a;
  logic               mult_c, no_borrow;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign op_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_rs (
    .val_i(rs_val), .neg_i(in_signed & rs_val[WIDTH-1]), .res_o(rs_mag)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_abs_rt (
    .val_i(rt_val), .neg_i(in_signed & rt_val[WIDTH-1]), .res_o(rt_mag)
  );
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val_i({acc_q, shq_q}), .neg_i(negq_q), .res_o(prod_fix)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val_i(shq_q), .neg_i(negq_q), .res_o(quo_fix)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q), .neg_i(negr_q), .res_o(rem_fix)
  );

  // Carry-out / no-borrow rebuilt from operand and result MSBs, since the ALU exports neither.
  assign mult_b    = shq_q[0] ? opnd_q : '0;
  assign div_a     = {acc_q[WIDTH-2:0], shq_q[WIDTH-1]};
  assign mult_c    = (acc_q[WIDTH-1] & mult_b[WIDTH-1]) |
                     ((acc_q[WIDTH-1] | mult_b[WIDTH-1]) & ~alu_result[WIDTH-1]);
  assign no_borrow = (div_a[WIDTH-1] & ~opnd_q[WIDTH-1]) |
                     ((div_a[WIDTH-1] | ~opnd_q[WIDTH-1]) & ~alu_result[WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    shq_d    = shq_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          negq_d = in_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          negr_d = in_signed & rs_val[WIDTH-1];
          cnt_d  = '0;
          acc_d  = '0;
          div0_d = in_div && (rt_val == '0);
          if (in_div) begin
            shq_d  = rs_mag;
            opnd_d = rt_mag;
          end else begin
            shq_d  = rt_mag;
            opnd_d = rs_mag;
          end
          if (in_div && (rt_val == '0)) begin
            acc_d   = rs_val;
            state_d = ST_FIX;
          end else begin
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_div) begin
          alu_a    = acc_q;
          alu_b    = mult_b;
          alu_ctrl = ALU_ADD;
          acc_d    = {mult_c, alu_result[WIDTH-1:1]};
          shq_d    = {alu_result[0], shq_q[WIDTH-1:1]};
        end else begin
          alu_a    = div_a;
          alu_b    = opnd_q;
          alu_ctrl = ALU_SUB;
          if (acc_q[WIDTH-1] | no_borrow) begin
            acc_d = alu_result;
            shq_d = {shq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_a;
            shq_d = {shq_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_W'(31)) state_d = ST_FIX;
      end

      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (div0_q) begin
          hi_d = acc_q;
          lo_d = DIV0_LO;
        end else if (!op_div) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      shq_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      shq_q   <= shq_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural add/sub ALU in the loop.
module tb_muldiv_seq;
  import mips_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_seq #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb alu_result = (alu_ctrl == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done) begin
      chk("done_without_busy", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        chk({e.tag, "_done_cycle"}, cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input string tag);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.hi = eh; e.lo = el; e.due = cyc + lat; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_done(output int busy_cyc, output int ctrl_bad);
    busy_cyc = 0;
    ctrl_bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (busy) busy_cyc++;
      if (busy && alu_ctrl != ALU_ADD) ctrl_bad++;
      if (!busy && sb.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: got no done within 80 cycles expected done");
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int bc, cb;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("idle_alu_ctrl", {28'b0, alu_ctrl}, 32'h2);
    chk("idle_alu_a", alu_a, 32'd0);
    chk("idle_alu_b", alu_b, 32'd0);
    rst_n = 1'b1;

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max");
    wait_done(bc, cb);
    chk("multu_busy_cycles", bc, 32'd33);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult_neg3x7");
    wait_done(bc, cb);
    chk("mult_iter_alu_ctrl_not_add", cb, 32'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_100_7");
    wait_done(bc, cb);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg7_2");
    wait_done(bc, cb);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, "div_7_neg2");
    wait_done(bc, cb);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, "div_min_neg1");
    wait_done(bc, cb);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 33, "mult_min_min");
    wait_done(bc, cb);

    issue(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, "divu_by0");
    wait_done(bc, cb);
    chk("divu_by0_busy_cycles", bc, 32'd1);
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, "div_by0_neg");
    wait_done(bc, cb);

    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_ign_start");
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(bc, cb);

    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 33, "aborted");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    rst_n = 1'b1;

    issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, "multu_3x4");
    wait_done(bc, cb);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
